// File: rtl/rf_writeback.sv
// rf_writeback: writeback GPR/flag register file with retire counter and sticky illegal halt; define RF_BYPASS_EN for same-cycle write-through reads
module rf_writeback #(
  parameter int NREGS = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic          wb_rf_we,
  input  logic [2:0]    wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  input  logic          wb_ccr_we_c,
  input  logic          wb_ccr_we_z,
  input  logic          wb_c,
  input  logic          wb_z,
  input  logic          wb_illegal,
  input  logic [2:0]    raddr_a,
  input  logic [2:0]    raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          flag_c,
  output logic          flag_z,
  output logic [15:0]   retired,
  output logic          halted
);
  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];
  logic          flag_c_q, flag_c_d, flag_z_q, flag_z_d, halted_q, halted_d;
  logic [15:0]   retired_q, retired_d;
  logic          commit, rf_wr, c_wr, z_wr;
  assign commit = wb_valid & ~halted_q;
  assign rf_wr  = commit & wb_rf_we;
  assign c_wr   = commit & wb_ccr_we_c;
  assign z_wr   = commit & wb_ccr_we_z;
  always_comb begin
    for (int i = 0; i < NREGS; i++)
      regs_d[i] = (rf_wr && wb_waddr == 3'(i)) ? wb_wdata : regs_q[i];
    flag_c_d  = c_wr ? wb_c : flag_c_q;
    flag_z_d  = z_wr ? wb_z : flag_z_q;
    retired_d = commit ? retired_q + 16'd1 : retired_q;
    halted_d  = halted_q | (commit & wb_illegal);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q    <= '{default: '0};
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      retired_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      flag_c_q  <= flag_c_d;
      flag_z_q  <= flag_z_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
    end
  end
`ifdef RF_BYPASS_EN
  assign rdata_a = (rf_wr && wb_waddr == raddr_a) ? wb_wdata : regs_q[raddr_a];
  assign rdata_b = (rf_wr && wb_waddr == raddr_b) ? wb_wdata : regs_q[raddr_b];
  assign flag_c  = c_wr ? wb_c : flag_c_q;
  assign flag_z  = z_wr ? wb_z : flag_z_q;
`else
  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
  assign flag_c  = flag_c_q;
  assign flag_z  = flag_z_q;
`endif
  assign retired = retired_q;
  assign halted  = halted_q;
endmodule

// File: doc/rf_writeback.md
# rf_writeback

Writeback-side register file of the 5-stage core: it commits results from the MEM/WB pipeline register into the eight 16-bit GPRs and the C/Z flag register. It serves the two combinational read ports used by the operand-fetch (RF) stage, with optional same-cycle write-through. It also maintains a retired-instruction counter and a sticky halt on illegal instructions.

## Interface
- Parameters:
- NREGS, 8, number of GPRs (address width fixed at 3)
- DW, 16, data width
- Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- wb_valid  in  1  MEM/WB holds a real instruction this cycle
- wb_rf_we  in  1  committed GPR write enable (predicate already resolved)
- wb_waddr  in  3  GPR destination
- wb_wdata  in  16  GPR write data
- wb_ccr_we_c  in  1  committed carry write enable
- wb_ccr_we_z  in  1  committed zero write enable
- wb_c  in  1  new carry value
- wb_z  in  1  new zero value
- wb_illegal  in  1  retiring instruction is illegal
- raddr_a  in  3  read port A address (ra)
- raddr_b  in  3  read port B address (rb)
- rdata_a  out  16  read port A data
- rdata_b  out  16  read port B data
- flag_c  out  1  current carry
- flag_z  out  1  current zero
- retired  out  16  retired-instruction count
- halted  out  1  sticky halt after illegal retire

## Operation
- Commit qualifier: commit = wb_valid & ~halted. All writes and the retire count are gated by commit.
- GPR write: at posedge, if commit & wb_rf_we, then regs[wb_waddr] <= wb_wdata. Every register, including R0, is writable.
- Flag write: C and Z update independently at posedge under commit & wb_ccr_we_c and commit & wb_ccr_we_z respectively.
- Retire: each commit cycle increments retired by 1, including instructions with no writes and illegal ones. It wraps modulo 2^16, from 0xFFFF to 0x0000.
- Illegal: commit & wb_illegal sets halted at posedge. That instruction's own writes still commit in the same cycle. From the next cycle on, all further commits are blocked.
- Read ports are combinational. rdata_x = regs[raddr_x], subject to the bypass rule under Configuration.
- When both read ports address the same register, each returns identical data.
- Writes with wb_valid=0 are ignored, whatever the enable inputs.

## Timing
- Reset, synchronous, with rst dominant over a same-cycle commit:
  - all regs = 0x0000
  - flag_c = 0, flag_z = 0
  - retired = 0x0000
  - halted = 0
  - rdata_a and rdata_b therefore read 0x0000 in the cycle after rst.
- Without bypass, write-to-read latency is 1 cycle: data written at edge N is readable after edge N.
- Reset asserted mid-stream discards the in-flight commit. Nothing from that cycle is retained.
- halted is observable 1 cycle after the illegal commit.
- retired reflects commits through the previous edge.

## Configuration
- RF_BYPASS_EN defined:
  - If commit & wb_rf_we & (wb_waddr == raddr_x) in the current cycle, rdata_x = wb_wdata in the same cycle.
  - flag_c and flag_z likewise return wb_c / wb_z when their write is committing.
  - The RF stage sees the writeback result with zero extra delay.
- RF_BYPASS_EN undefined:
  - Reads return array contents only, i.e. the pre-write value in the write cycle.
  - The hazard unit must stall one additional cycle for WB→RF dependencies.

## Test plan
- Reset then read: assert rst 1 cycle, then raddr_a=3, raddr_b=7 → rdata_a=0x0000, rdata_b=0x0000, flag_c=0, flag_z=0, retired=0, halted=0.
- Basic write/read: commit R5=0xBEEF, next cycle raddr_a=5 → rdata_a=0xBEEF, retired=1. A write with wb_valid=0 to R5=0x1234 → R5 stays 0xBEEF.
- Same-cycle bypass: commit R2=0xA5A5 while raddr_a=raddr_b=2.
  - With RF_BYPASS_EN: both ports read 0xA5A5 in that cycle.
  - Without RF_BYPASS_EN: both read the old value, and 0xA5A5 the next cycle.
- Flags: commit with wb_ccr_we_c=1, wb_c=1 and wb_ccr_we_z=0, wb_z=1 → flag_c=1, flag_z stays 0. Next, commit with only Z enabled, wb_z=1 → flag_c=1, flag_z=1.
- Illegal halt: commit R1=0x0011 with wb_illegal=1 → R1=0x0011, halted=1, retired incremented. A following commit of R1=0x0022 → R1 stays 0x0011, retired unchanged. Then rst → halted=0.
- Counter wrap: drive 65536 consecutive commits → retired returns to 0x0000. An rst asserted in the same cycle as a commit → retired=0 and the write is not performed.
